// File: rtl/viterbi_frame_seq_if.sv
// Handshake/data bundle between the Viterbi frame sequencer and its environment.
//   slave  : sequencer side (viterbi_frame_seq)
//   master : environment side (frame control, encoder/channel/decoder loop)
// Signals:
//   start_i       start one frame (sampled only while idle)
//   frame_len_i   data bits per frame
//   err_period_i  injection period in encoded symbols, 0 = off
//   err_burst_i   corrupted symbols at the start of each period
//   enc_bit_o     data bit to the encoder
//   enc_en_o      encoder enable
//   inj_mask_o    XOR mask for the 2-bit encoded symbol
//   dec_bit_i     decoder output bit
//   busy_o        frame in progress (RUN through DONE)
//   done_o        one-cycle pulse at frame completion
//   bit_err_cnt_o mismatched data bits
//   inj_cnt_o     corrupted symbols
//   max_run_o     longest streak of consecutive bit errors
interface viterbi_frame_seq_if #(
    parameter int unsigned FRAME_W = 16,
    parameter int unsigned CNT_W   = 16
);
    logic               start_i;
    logic [FRAME_W-1:0] frame_len_i;
    logic [7:0]         err_period_i;
    logic [7:0]         err_burst_i;
    logic               enc_bit_o;
    logic               enc_en_o;
    logic [1:0]         inj_mask_o;
    logic               dec_bit_i;
    logic               busy_o;
    logic               done_o;
    logic [CNT_W-1:0]   bit_err_cnt_o;
    logic [CNT_W-1:0]   inj_cnt_o;
    logic [CNT_W-1:0]   max_run_o;

    modport master (
        output start_i, frame_len_i, err_period_i, err_burst_i, dec_bit_i,
        input  enc_bit_o, enc_en_o, inj_mask_o, busy_o, done_o,
               bit_err_cnt_o, inj_cnt_o, max_run_o
    );

    modport slave (
        input  start_i, frame_len_i, err_period_i, err_burst_i, dec_bit_i,
        output enc_bit_o, enc_en_o, inj_mask_o, busy_o, done_o,
               bit_err_cnt_o, inj_cnt_o, max_run_o
    );
endinterface

// File: rtl/viterbi_frame_seq.sv
// Frame sequencer and self-check controller for the encoder -> channel -> Viterbi decoder loop.
// Generates a PRBS data frame, zero-tail flushes the trellis, waits out the decoder latency,
// and compares decoder output against a delayed copy of the sent data bits. Also schedules
// periodic burst error injection on the encoded symbols and counts injected symbols.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  viterbi_frame_seq_if.slave (control, encoder/decoder loop, statistics)
// Optional feature: define VITERBI_SEQ_STATS_EN to build the longest-error-run tracker
// (max_run_o); otherwise max_run_o is tied to zero.
module viterbi_frame_seq #(
    parameter int unsigned FRAME_W     = 16,
    parameter int unsigned TAIL_LEN    = 6,
    parameter int unsigned DEC_LATENCY = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    viterbi_frame_seq_if.slave bus
);

    // Phase counter must hold frame_len-1, TAIL_LEN-1 and DEC_LATENCY-1.
    localparam int unsigned TAIL_W = $clog2(TAIL_LEN + 1);
    localparam int unsigned LAT_W  = $clog2(DEC_LATENCY + 1);
    localparam int unsigned PH_W0  = (FRAME_W > TAIL_W) ? FRAME_W : TAIL_W;
    localparam int unsigned PH_W   = (PH_W0 > LAT_W) ? PH_W0 : LAT_W;

    typedef enum logic [2:0] {StIdle, StRun, StFlush, StDrain, StDone} state_e;

    state_e             state;
    logic [PH_W-1:0]    phase;
    logic [FRAME_W-1:0] frame_len;
    logic [7:0]         err_period;
    logic [7:0]         err_burst;
    logic [15:0]        lfsr;
    logic               enc_en;
    logic               enc_bit;
    logic               busy;
    logic               done;

    logic [7:0]         sym_cnt;
    logic [1:0]         inj_mask;
    logic [CNT_W-1:0]   inj_cnt;
    logic [CNT_W-1:0]   bit_err_cnt;
    // {is_data_bit, sent_bit}, aligned with dec_bit_i at the far end
    logic [1:0]         dly [DEC_LATENCY];

    logic [15:0]        lfsr_next;
    logic [PH_W-1:0]    len_last;
    logic               accept;
    logic               chk_valid;
    logic               chk_err;
    logic               inj_hit;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting right, output at bit 0
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign len_last  = PH_W'(frame_len) - PH_W'(1);
    assign accept    = (state == StIdle) && bus.start_i;
    assign chk_valid = dly[DEC_LATENCY-1][1];
    assign chk_err   = chk_valid && (bus.dec_bit_i != dly[DEC_LATENCY-1][0]);
    assign inj_hit   = enc_en && (err_period != 8'd0) && (sym_cnt < err_burst);

    // Sequencing FSM; all loop-facing control outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            phase      <= '0;
            frame_len  <= '0;
            err_period <= '0;
            err_burst  <= '0;
            lfsr       <= LFSR_SEED;
            enc_en     <= 1'b0;
            enc_bit    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start_i) begin
                        frame_len  <= bus.frame_len_i;
                        err_period <= bus.err_period_i;
                        err_burst  <= bus.err_burst_i;
                        lfsr       <= LFSR_SEED;
                        phase      <= '0;
                        busy       <= 1'b1;
                        enc_en     <= 1'b1;
                        if (bus.frame_len_i == '0) begin
                            state   <= StFlush;
                            enc_bit <= 1'b0;
                        end else begin
                            state   <= StRun;
                            enc_bit <= LFSR_SEED[0];
                        end
                    end
                end
                StRun: begin
                    if (phase == len_last) begin
                        state   <= StFlush;
                        phase   <= '0;
                        enc_bit <= 1'b0;
                    end else begin
                        phase   <= phase + PH_W'(1);
                        lfsr    <= lfsr_next;
                        enc_bit <= lfsr_next[0];
                    end
                end
                StFlush: begin
                    if (phase == PH_W'(TAIL_LEN - 1)) begin
                        state  <= StDrain;
                        phase  <= '0;
                        enc_en <= 1'b0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                StDrain: begin
                    if (phase == PH_W'(DEC_LATENCY - 1)) begin
                        state <= StDone;
                        phase <= '0;
                        done  <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Check delay line, injection scheduling and statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_cnt     <= '0;
            inj_mask    <= '0;
            inj_cnt     <= '0;
            bit_err_cnt <= '0;
            for (int i = 0; i < DEC_LATENCY; i++) dly[i] <= '0;
        end else begin
            // enc_bit is zero outside RUN, so only RUN entries carry data
            dly[0] <= {state == StRun, enc_bit};
            for (int i = 1; i < DEC_LATENCY; i++) dly[i] <= dly[i-1];

            if (accept) begin
                sym_cnt     <= '0;
                inj_mask    <= '0;
                inj_cnt     <= '0;
                bit_err_cnt <= '0;
            end else begin
                // Mask lands one cycle after its symbol, matching the encoder's registered output
                inj_mask <= inj_hit ? 2'b11 : 2'b00;
                if (inj_hit && (inj_cnt != '1)) inj_cnt <= inj_cnt + CNT_W'(1);
                if (enc_en) begin
                    if ((err_period == 8'd0) || (sym_cnt == err_period - 8'd1)) sym_cnt <= '0;
                    else sym_cnt <= sym_cnt + 8'd1;
                end
                if (chk_err && (bit_err_cnt != '1)) bit_err_cnt <= bit_err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef VITERBI_SEQ_STATS_EN
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] max_run;
    logic [CNT_W-1:0] run_inc;

    assign run_inc = (run_len == '1) ? run_len : run_len + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len <= '0;
            max_run <= '0;
        end else if (accept) begin
            run_len <= '0;
            max_run <= '0;
        end else if (chk_valid) begin
            if (chk_err) begin
                run_len <= run_inc;
                if (run_inc > max_run) max_run <= run_inc;
            end else begin
                run_len <= '0;
            end
        end
    end

    assign bus.max_run_o = max_run;
`else
    assign bus.max_run_o = '0;
`endif

    assign bus.enc_bit_o     = enc_bit;
    assign bus.enc_en_o      = enc_en;
    assign bus.inj_mask_o    = inj_mask;
    assign bus.busy_o        = busy;
    assign bus.done_o        = done;
    assign bus.bit_err_cnt_o = bit_err_cnt;
    assign bus.inj_cnt_o     = inj_cnt;

endmodule

// File: tb/tb_viterbi_frame_seq.sv
// Self-checking bench for viterbi_frame_seq: ideal/inverting decoder model, PRBS reference,
// expected per-frame results queued at start and compared at done_o.
module tb_viterbi_frame_seq;

    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned TAIL_LEN = 6;
    localparam int unsigned DL       = 64;
    localparam int unsigned CNT_W    = 16;
    localparam logic [15:0] SEED     = 16'hACE1;

    typedef struct {
        int bit_err;
        int inj;
        int max_run;
        int busy;
        int en_cyc;
    } exp_t;

    logic clk;
    logic rst;

    viterbi_frame_seq_if #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) bus ();

    viterbi_frame_seq #(
        .FRAME_W    (FRAME_W),
        .TAIL_LEN   (TAIL_LEN),
        .DEC_LATENCY(DL),
        .LFSR_SEED  (SEED),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   frames_done = 0;

    // Per-frame monitor state
    int          cur_len = 0;
    bit          flip_en = 1'b0;
    int          idx = 0;
    logic [15:0] m_lfsr = SEED;
    int          busy_cyc = 0;
    int          data_mis = 0;
    int          tail_ones = 0;
    int          mask_cyc = 0;
    int          mask_bad = 0;
    logic        prev_en = 1'b0;

    // Decoder model: sent bit (optionally inverted) delayed so it meets the DUT's compare
    logic        tdl [0:DL];

    assign bus.dec_bit_i = tdl[DL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    initial begin
        for (int k = 0; k <= DL; k++) tdl[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = DL; k > 0; k--) tdl[k] = tdl[k-1];
            tdl[0] = bus.enc_bit_o ^ (bus.enc_en_o && flip_en && idx >= 10 && idx <= 12);
            if (bus.busy_o) busy_cyc++;
            if (bus.enc_en_o) begin
                if (idx < cur_len) begin
                    if (bus.enc_bit_o !== m_lfsr[0]) data_mis++;
                    m_lfsr = lfsr_step(m_lfsr);
                end else if (bus.enc_bit_o !== 1'b0) begin
                    tail_ones++;
                end
                idx++;
            end
            if (bus.inj_mask_o == 2'b11) mask_cyc++;
            if (!prev_en && bus.inj_mask_o != 2'b00) mask_bad++;
            if (bus.inj_mask_o != 2'b00 && bus.inj_mask_o != 2'b11) mask_bad++;
            prev_en = bus.enc_en_o;
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("bit_err_cnt", 32'(bus.bit_err_cnt_o), 32'(e.bit_err));
                    check("inj_cnt", 32'(bus.inj_cnt_o), 32'(e.inj));
                    check("max_run", 32'(bus.max_run_o), 32'(e.max_run));
                    check("busy_cycles", 32'(busy_cyc), 32'(e.busy));
                    check("enc_en_cycles", 32'(idx), 32'(e.en_cyc));
                    check("mask_cycles", 32'(mask_cyc), 32'(e.inj));
                    check("prbs_data", 32'(data_mis), 32'd0);
                    check("tail_zero", 32'(tail_ones), 32'd0);
                    check("mask_timing", 32'(mask_bad), 32'd0);
                end
                frames_done++;
            end
        end
    end

    task automatic start_frame(input int len, input int per, input int bur, input bit inv,
                               input bit expect_done);
        exp_t e;
        int   run;
        int   mx;
        @(negedge clk);
        e.inj = 0;
        for (int i = 0; i < len + int'(TAIL_LEN); i++)
            if (per != 0 && (i % per) < bur) e.inj++;
        e.bit_err = 0;
        run = 0;
        mx  = 0;
        for (int i = 0; i < len; i++) begin
            if (inv && i >= 10 && i <= 12) begin
                e.bit_err++;
                run++;
                if (run > mx) mx = run;
            end else begin
                run = 0;
            end
        end
`ifdef VITERBI_SEQ_STATS_EN
        e.max_run = mx;
`else
        e.max_run = 0;
`endif
        e.busy   = len + int'(TAIL_LEN) + int'(DL) + 1;
        e.en_cyc = len + int'(TAIL_LEN);
        if (expect_done) sb.push_back(e);
        cur_len   = len;
        flip_en   = inv;
        idx       = 0;
        m_lfsr    = SEED;
        busy_cyc  = 0;
        data_mis  = 0;
        tail_ones = 0;
        mask_cyc  = 0;
        mask_bad  = 0;
        bus.frame_len_i  = FRAME_W'(len);
        bus.err_period_i = 8'(per);
        bus.err_burst_i  = 8'(bur);
        bus.start_i      = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 2000 && frames_done < target; i++) @(negedge clk);
        check("done_reached", 32'(frames_done), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({bus.enc_bit_o, bus.enc_en_o, bus.inj_mask_o, bus.busy_o,
                                    bus.done_o}), 32'd0);
        check({tag, "_cnts"}, 32'({bus.bit_err_cnt_o, bus.inj_cnt_o}), 32'd0);
        check({tag, "_maxrun"}, 32'(bus.max_run_o), 32'd0);
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.frame_len_i  = '0;
        bus.err_period_i = '0;
        bus.err_burst_i  = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Reset in the middle of a RUN with injection active: no done, everything cleared
        start_frame(100, 3, 1, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        check("midrun_busy", 32'(bus.busy_o), 32'd1);
        check("midrun_inj_nonzero", 32'(bus.inj_cnt_o != '0), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Clean frame, no injection, ideal decoder
        start_frame(256, 0, 0, 1'b0, 1'b1);
        wait_done(1);

        // Periodic bursts of two every 32 symbols
        start_frame(256, 32, 2, 1'b0, 1'b1);
        wait_done(2);

        // Decoder inverting data bits 10..12
        start_frame(64, 0, 0, 1'b1, 1'b1);
        wait_done(3);

        // Empty frame; a start pulse while busy must be ignored
        start_frame(0, 0, 0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        bus.frame_len_i = FRAME_W'(5);
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(4);

        // Burst longer than period: every symbol corrupted
        start_frame(40, 4, 5, 1'b0, 1'b1);
        wait_done(5);

        repeat (20) @(negedge clk);
        check("total_done", 32'(frames_done), 32'd5);
        check("queue_empty", 32'(sb.size()), 32'd0);
        check("idle_busy", 32'(bus.busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
